// File: rtl/ttt_turn_ctrl.sv
// Turn scheduler and game controller for the 9-cell x 2-bank tic-tac-toe latch array.
// Optional macro TTT_WIN_MASK_EN adds the win_mask output.
module ttt_turn_ctrl #(
    parameter int START_PLAYER = 0,
    parameter int TURN_TIMEOUT = 0,
    parameter int TMR_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] latch_out,
    output logic [17:0] mem,
    output logic [8:0]  x_cells,
    output logic [8:0]  o_cells,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        move_err,
`ifdef TTT_WIN_MASK_EN
    output logic [8:0]  win_mask,
`endif
    output logic        timeout_pulse
);

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_RELEASE, S_CHECK, S_DONE} state_t;
    typedef enum logic [1:0] {ACT_MOVE, ACT_ERR, ACT_TMO} act_t;

    localparam logic START_BIT = START_PLAYER[0];
    localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                         9'h092, 9'h124, 9'h111, 9'h054};

    state_t           state_q, state_d;
    act_t             act_q, act_d;
    logic [8:0]       xCells_q, xCells_d;
    logic [8:0]       oCells_q, oCells_d;
    logic             turn_q, turn_d;
    logic [1:0]       winner_q, winner_d;
    logic             moveErr_q, moveErr_d;
    logic             tmo_q, tmo_d;
    logic [TMR_W-1:0] timer_q, timer_d;
`ifdef TTT_WIN_MASK_EN
    logic [8:0]       winMask_q, winMask_d;
`endif

    logic [8:0] freeCells, sel, moverBoard, moverLines;
    logic       onePress, multiPress, timerExpired;

    // OR of every fully owned line on a board; non-zero means a win.
    function automatic logic [8:0] lineMask(input logic [8:0] b);
        logic [8:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            if ((b & LINES[k]) == LINES[k]) m = m | LINES[k];
        end
        return m;
    endfunction

    assign freeCells    = ~(xCells_q | oCells_q);
    assign sel          = (turn_q ? latch_out[17:9] : latch_out[8:0]) & freeCells;
    assign multiPress   = (sel & (sel - 9'd1)) != 9'd0;
    assign onePress     = (sel != 9'd0) && !multiPress;
    assign timerExpired = (TURN_TIMEOUT != 0) && (timer_q == TMR_W'(TURN_TIMEOUT - 1));
    assign moverBoard   = turn_q ? oCells_q : xCells_q;
    assign moverLines   = lineMask(moverBoard);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            act_q     <= ACT_MOVE;
            xCells_q  <= '0;
            oCells_q  <= '0;
            turn_q    <= START_BIT;
            winner_q  <= 2'b00;
            moveErr_q <= 1'b0;
            tmo_q     <= 1'b0;
            timer_q   <= '0;
`ifdef TTT_WIN_MASK_EN
            winMask_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            xCells_q  <= xCells_d;
            oCells_q  <= oCells_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
            moveErr_q <= moveErr_d;
            tmo_q     <= tmo_d;
            timer_q   <= timer_d;
`ifdef TTT_WIN_MASK_EN
            winMask_q <= winMask_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        xCells_d  = xCells_q;
        oCells_d  = oCells_q;
        turn_d    = turn_q;
        winner_d  = winner_q;
        moveErr_d = 1'b0;
        tmo_d     = 1'b0;
        timer_d   = '0;
`ifdef TTT_WIN_MASK_EN
        winMask_d = winMask_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    xCells_d = '0;
                    oCells_d = '0;
                    turn_d   = START_BIT;
                    winner_d = 2'b00;
`ifdef TTT_WIN_MASK_EN
                    winMask_d = '0;
`endif
                    state_d  = S_PLAY;
                end
            end
            S_PLAY: begin
                timer_d = timer_q + TMR_W'(1);
                // A press always wins over an expiring timer in the same cycle.
                if (onePress) begin
                    if (turn_q) oCells_d = oCells_q | sel;
                    else        xCells_d = xCells_q | sel;
                    act_d   = ACT_MOVE;
                    state_d = S_RELEASE;
                end else if (multiPress) begin
                    moveErr_d = 1'b1;
                    act_d     = ACT_ERR;
                    state_d   = S_RELEASE;
                end else if (timerExpired) begin
                    tmo_d   = 1'b1;
                    act_d   = ACT_TMO;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_CHECK;
            S_CHECK: begin
                state_d = S_PLAY;
                if (act_q == ACT_MOVE) begin
                    if (moverLines != 9'd0) begin
                        winner_d = turn_q ? 2'b10 : 2'b01;
`ifdef TTT_WIN_MASK_EN
                        winMask_d = moverLines;
`endif
                        state_d  = S_DONE;
                    end else if ((xCells_q | oCells_q) == 9'h1FF) begin
                        winner_d = 2'b11;
`ifdef TTT_WIN_MASK_EN
                        winMask_d = '0;
`endif
                        state_d  = S_DONE;
                    end else begin
                        turn_d = ~turn_q;
                    end
                end else if (act_q == ACT_TMO) begin
                    turn_d = ~turn_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enable mask depends only on registered state, never on latch_out.
    always_comb begin
        mem = '0;
        if (state_q == S_PLAY) begin
            if (turn_q) mem[17:9] = freeCells;
            else        mem[8:0]  = freeCells;
        end
    end

    assign x_cells       = xCells_q;
    assign o_cells       = oCells_q;
    assign turn          = turn_q;
    assign game_over     = (state_q == S_DONE);
    assign winner        = winner_q;
    assign move_err      = moveErr_q;
    assign timeout_pulse = tmo_q;
`ifdef TTT_WIN_MASK_EN
    assign win_mask      = winMask_q;
`endif

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed testbench for ttt_turn_ctrl (X starts, 8-cycle turn timeout).
// Honours TTT_WIN_MASK_EN when the design is built with it.
module tb_ttt_turn_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [17:0] latch_out;
    logic [17:0] mem;
    logic [8:0]  x_cells, o_cells;
    logic        turn, game_over, move_err, timeout_pulse;
    logic [1:0]  winner;
`ifdef TTT_WIN_MASK_EN
    logic [8:0]  win_mask;
`endif

    int passCount  = 0;
    int totalCount = 0;

    ttt_turn_ctrl #(.START_PLAYER(0), .TURN_TIMEOUT(8), .TMR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .latch_out(latch_out),
        .mem(mem), .x_cells(x_cells), .o_cells(o_cells), .turn(turn),
        .game_over(game_over), .winner(winner), .move_err(move_err),
`ifdef TTT_WIN_MASK_EN
        .win_mask(win_mask),
`endif
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One latch bit for one edge, then two edges to reach the next PLAY or DONE.
    task automatic press(input int bitIdx);
        latch_out = 18'd1 << bitIdx;
        tick();
        latch_out = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; latch_out = '0;
        tick(); tick();
        if (x_cells !== 9'h000) $display("[TB] FAIL rst_x: got %h expected 000", x_cells); else passCount++; totalCount++;
        if (o_cells !== 9'h000) $display("[TB] FAIL rst_o: got %h expected 000", o_cells); else passCount++; totalCount++;
        if (mem !== 18'h0) $display("[TB] FAIL rst_mem: got %h expected 0", mem); else passCount++; totalCount++;
        if (turn !== 1'b0) $display("[TB] FAIL rst_turn: got %b expected 0", turn); else passCount++; totalCount++;
        if (winner !== 2'b00) $display("[TB] FAIL rst_winner: got %b expected 00", winner); else passCount++; totalCount++;
        if ({game_over, move_err, timeout_pulse} !== 3'b000) $display("[TB] FAIL rst_flags: got %b expected 000", {game_over, move_err, timeout_pulse}); else passCount++; totalCount++;
        reset = 1'b0;
        tick();
        if (mem !== 18'h0) $display("[TB] FAIL idle_mem: got %h expected 0", mem); else passCount++; totalCount++;
    endtask

    task automatic test_x_diag_win();
        pulseStart();
        if (mem !== 18'h001FF) $display("[TB] FAIL win_start_mem: got %h expected 001ff", mem); else passCount++; totalCount++;
        press(0);
        if (turn !== 1'b1) $display("[TB] FAIL win_turn1: got %b expected 1", turn); else passCount++; totalCount++;
        if (mem !== 18'h3FC00) $display("[TB] FAIL win_mem_o: got %h expected 3fc00", mem); else passCount++; totalCount++;
        press(10); press(4); press(11);
        latch_out = 18'd1 << 8;
        tick();
        if (x_cells !== 9'h111) $display("[TB] FAIL win_board_edge: got %h expected 111", x_cells); else passCount++; totalCount++;
        if (mem !== 18'h0) $display("[TB] FAIL win_release_mem: got %h expected 0", mem); else passCount++; totalCount++;
        latch_out = '0;
        tick();
        if (game_over !== 1'b0) $display("[TB] FAIL win_early_done: got %b expected 0", game_over); else passCount++; totalCount++;
        tick();
        if (game_over !== 1'b1) $display("[TB] FAIL win_game_over: got %b expected 1", game_over); else passCount++; totalCount++;
        if (winner !== 2'b01) $display("[TB] FAIL win_winner: got %b expected 01", winner); else passCount++; totalCount++;
        if (o_cells !== 9'h006) $display("[TB] FAIL win_o: got %h expected 006", o_cells); else passCount++; totalCount++;
        if (mem !== 18'h0) $display("[TB] FAIL win_done_mem: got %h expected 0", mem); else passCount++; totalCount++;
`ifdef TTT_WIN_MASK_EN
        if (win_mask !== 9'h111) $display("[TB] FAIL win_mask: got %h expected 111", win_mask); else passCount++; totalCount++;
`endif
    endtask

    task automatic test_draw();
        int seq [9] = '{0, 10, 2, 13, 3, 14, 7, 15, 8};
        pulseStart();
        if ({x_cells, o_cells} !== 18'h0) $display("[TB] FAIL draw_clear: got %h expected 0", {x_cells, o_cells}); else passCount++; totalCount++;
        if (winner !== 2'b00) $display("[TB] FAIL draw_winner_clr: got %b expected 00", winner); else passCount++; totalCount++;
        for (int i = 0; i < 9; i++) press(seq[i]);
        if (winner !== 2'b11) $display("[TB] FAIL draw_winner: got %b expected 11", winner); else passCount++; totalCount++;
        if (x_cells !== 9'h18D) $display("[TB] FAIL draw_x: got %h expected 18d", x_cells); else passCount++; totalCount++;
        if (o_cells !== 9'h072) $display("[TB] FAIL draw_o: got %h expected 072", o_cells); else passCount++; totalCount++;
        if (game_over !== 1'b1) $display("[TB] FAIL draw_game_over: got %b expected 1", game_over); else passCount++; totalCount++;
`ifdef TTT_WIN_MASK_EN
        if (win_mask !== 9'h000) $display("[TB] FAIL draw_win_mask: got %h expected 000", win_mask); else passCount++; totalCount++;
`endif
    endtask

    task automatic test_multi_press();
        pulseStart();
        latch_out = 18'h0000C;
        tick();
        if (move_err !== 1'b1) $display("[TB] FAIL mp_err_pulse: got %b expected 1", move_err); else passCount++; totalCount++;
        if (mem !== 18'h0) $display("[TB] FAIL mp_release_mem: got %h expected 0", mem); else passCount++; totalCount++;
        if (x_cells !== 9'h000) $display("[TB] FAIL mp_no_commit: got %h expected 000", x_cells); else passCount++; totalCount++;
        latch_out = '0;
        tick();
        if (move_err !== 1'b0) $display("[TB] FAIL mp_err_single: got %b expected 0", move_err); else passCount++; totalCount++;
        tick();
        if (turn !== 1'b0) $display("[TB] FAIL mp_turn: got %b expected 0", turn); else passCount++; totalCount++;
        if (mem !== 18'h001FF) $display("[TB] FAIL mp_reenable: got %h expected 001ff", mem); else passCount++; totalCount++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 7; i++) tick();
        if (timeout_pulse !== 1'b0) $display("[TB] FAIL tmo_early: got %b expected 0", timeout_pulse); else passCount++; totalCount++;
        if (mem !== 18'h001FF) $display("[TB] FAIL tmo_still_play: got %h expected 001ff", mem); else passCount++; totalCount++;
        tick();
        if (timeout_pulse !== 1'b1) $display("[TB] FAIL tmo_pulse: got %b expected 1", timeout_pulse); else passCount++; totalCount++;
        tick();
        if (timeout_pulse !== 1'b0) $display("[TB] FAIL tmo_single: got %b expected 0", timeout_pulse); else passCount++; totalCount++;
        tick();
        if (turn !== 1'b1) $display("[TB] FAIL tmo_turn: got %b expected 1", turn); else passCount++; totalCount++;
        if (mem !== 18'h3FE00) $display("[TB] FAIL tmo_mem_o: got %h expected 3fe00", mem); else passCount++; totalCount++;
        if ({x_cells, o_cells} !== 18'h0) $display("[TB] FAIL tmo_boards: got %h expected 0", {x_cells, o_cells}); else passCount++; totalCount++;
    endtask

    task automatic test_occupied();
        press(13);
        press(0);
        latch_out = 18'h00201;
        tick();
        if (mem !== 18'h3DC00) $display("[TB] FAIL occ_stay_play: got %h expected 3dc00", mem); else passCount++; totalCount++;
        if (move_err !== 1'b0) $display("[TB] FAIL occ_no_err: got %b expected 0", move_err); else passCount++; totalCount++;
        if (x_cells !== 9'h001) $display("[TB] FAIL occ_x: got %h expected 001", x_cells); else passCount++; totalCount++;
        if (o_cells !== 9'h010) $display("[TB] FAIL occ_o: got %h expected 010", o_cells); else passCount++; totalCount++;
        tick();
        if (mem !== 18'h3DC00) $display("[TB] FAIL occ_stay_play2: got %h expected 3dc00", mem); else passCount++; totalCount++;
        latch_out = '0;
    endtask

    task automatic test_reset_mid();
        press(17);
        if (o_cells !== 9'h110) $display("[TB] FAIL rm_o_before: got %h expected 110", o_cells); else passCount++; totalCount++;
        reset = 1'b1; start = 1'b1;
        tick();
        if ({x_cells, o_cells} !== 18'h0) $display("[TB] FAIL rm_boards: got %h expected 0", {x_cells, o_cells}); else passCount++; totalCount++;
        if (mem !== 18'h0) $display("[TB] FAIL rm_mem: got %h expected 0", mem); else passCount++; totalCount++;
        if ({turn, winner, game_over, move_err, timeout_pulse} !== 6'b0) $display("[TB] FAIL rm_flags: got %b expected 000000", {turn, winner, game_over, move_err, timeout_pulse}); else passCount++; totalCount++;
        reset = 1'b0; start = 1'b0;
        tick();
        if (mem !== 18'h0) $display("[TB] FAIL rm_idle: got %h expected 0", mem); else passCount++; totalCount++;
        pulseStart();
        if (mem !== 18'h001FF) $display("[TB] FAIL rm_new_game: got %h expected 001ff", mem); else passCount++; totalCount++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; latch_out = '0;
        test_reset();
        test_x_diag_win();
        test_draw();
        test_multi_press();
        test_timeout();
        test_occupied();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/ttt_turn_ctrl.md
Name: ttt_turn_ctrl

Overview:
- Turn scheduler and game controller for the 18-cell button-latch array: 9 cells × 2 player banks; bank X = bits [8:0], bank O = bits [17:9].
- Drives the per-latch enable mask so that only the active player's free cells can latch a press.
- Commits exactly one move per turn, clears all latches between turns, and detects win, draw and turn timeout.

Parameters:
- START_PLAYER, 0, player that moves first (0 = X, 1 = O).
- TURN_TIMEOUT, 0, clock cycles allowed per turn; 0 disables the timeout.
- TMR_W, 32, width of the turn timer; must hold TURN_TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; starts a new game from IDLE or DONE.
- latch_out  in  18  latch states from the array (1 = press latched); [8:0] X, [17:9] O.
- mem  out  18  latch enable mask to the array; 0 forces a latch clear.
- x_cells  out  9  cells owned by X.
- o_cells  out  9  cells owned by O.
- turn  out  1  active player (0 = X, 1 = O).
- game_over  out  1  high while in DONE.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- move_err  out  1  one-cycle pulse on a multi-cell press.
- timeout_pulse  out  1  one-cycle pulse when a turn expires.

Behaviour:
- Reset state: IDLE. x_cells, o_cells, mem, winner, game_over, move_err, timeout_pulse and timer are all 0; turn = START_PLAYER.
- Reset mid-game aborts immediately to the reset state.
- mem is decoded only from registered state; there is no combinational path from latch_out to mem.
  - PLAY: active bank bit i = ~(x_cells[i] | o_cells[i]); other bank = 0.
  - All other states: mem = 0.
- Only the active bank masked by free cells is sampled: sel = bank & free.
- IDLE: start → boards cleared, turn = START_PLAYER, winner = 00, go to PLAY. Otherwise stay in IDLE.
- PLAY (timer increments every cycle, cleared on entry):
  - popcount(sel) == 1: set that cell in the active player's board on this edge; act = MOVE; go to RELEASE.
  - popcount(sel) >= 2: no commit; move_err pulses next cycle; act = ERR; go to RELEASE.
  - popcount(sel) == 0 and TURN_TIMEOUT != 0 and timer == TURN_TIMEOUT-1: timeout_pulse pulses next cycle; act = TMO; go to RELEASE.
  - A press takes priority over a timeout in the same cycle.
- RELEASE: mem = 0 for exactly one cycle so every latch clears; go to CHECK.
- CHECK:
  - act = MOVE: evaluate the 8 lines (rows 012/345/678, cols 036/147/258, diags 048/246) on the mover's board.
    - Win → winner = mover code, go to DONE.
    - Else all 9 cells occupied → winner = 11, go to DONE.
    - Else toggle turn, go to PLAY.
  - act = TMO: toggle turn, go to PLAY.
  - act = ERR: same player retries, go to PLAY.
- DONE: game_over = 1; boards and winner held. start → clear boards, turn = START_PLAYER, winner = 00, go to PLAY.
- start is ignored in PLAY, RELEASE and CHECK.
- Latency from the sampling edge n (PLAY sees sel):
  - board updated after edge n;
  - mem = 0 during cycle n+1;
  - game_over high, or next player's mem valid, after edge n+2.
- Board invariant: x_cells & o_cells == 0 always. Pressed occupied cells are masked out and never committed.
- Simultaneous presses from the inactive bank are ignored (their mem is 0).

Optional Feature:
- Macro TTT_WIN_MASK_EN.
- Defined:
  - Adds output win_mask [8:0], registered in CHECK, equal to the OR of all completed lines of the winner.
  - Held in DONE; 0 on a draw, on reset and on start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- X diagonal win:
  - Sequence: START_PLAYER = 0; start; X presses 0, O 1, X 4, O 2, X 8 (one latch bit per turn).
  - Required: winner = 01, game_over = 1 two edges after sampling cell 8; x_cells = 0x111, o_cells = 0x006, mem = 0.
  - With TTT_WIN_MASK_EN: win_mask = 0x111.
- Draw:
  - Sequence: X 0, O 1, X 2, O 4, X 3, O 5, X 7, O 6, X 8.
  - Required: winner = 11, x_cells = 0x18D, o_cells = 0x072.
- Multi-press:
  - Stimulus: during X's turn, latch_out = 0x00C.
  - Required: one move_err pulse; boards unchanged; mem = 0 for one cycle; turn stays 0; X's free mask re-enabled.
- Timeout:
  - Stimulus: TURN_TIMEOUT = 8, no press for 8 cycles in PLAY.
  - Required: timeout_pulse once; turn 0 → 1; boards unchanged.
- Occupied / inactive bank:
  - Stimulus: on O's turn, latch_out sets bit 0 (X bank) and bit 9 while cell 0 is already owned by X.
  - Required: no commit, no move_err, state stays PLAY.
- Reset mid-game:
  - Stimulus: reset after 3 moves.
  - Required: next cycle all outputs 0, turn = START_PLAYER, state IDLE; start ignored only until IDLE is reached, then a new game begins.
